// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
// Shared types and defaults for the WS2812 chain driver.
//   state_e       : frame FSM states (IDLE, HIGH, LOW, LATCH)
//   DEF_*         : default timing constants for a 48 MHz clock
//   scale_byte()  : brightness scaling of one colour byte
// ---------------------------------------------------------------------------
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_e;

  localparam int DEF_NUM_LEDS  = 6;
  localparam int DEF_BIT_CYC   = 60;     // 1.25 us
  localparam int DEF_T0H_CYC   = 19;
  localparam int DEF_T1H_CYC   = 38;
  localparam int DEF_RESET_CYC = 14400;  // 300 us

  // (c * (b + 1)) >> 8 : b = 255 is identity, b = 0 blanks the byte.
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'h00, c} * ({8'h00, b} + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/ws2812_chain_driver_bit_timer.sv
// ---------------------------------------------------------------------------
// ws2812_bit_timer
// Produces the waveform of one serial bit: high for T1H_CYC/T0H_CYC cycles
// depending on bit_i, then low until BIT_CYC cycles have elapsed.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   go_i          : start a bit at this edge (line goes high from this edge)
//   bit_i         : value of the bit in flight (held stable by the caller)
//   line_o        : registered serial output
//   high_end_o    : last cycle of the high phase
//   bit_done_o    : last cycle of the bit period
// ---------------------------------------------------------------------------
module ws2812_bit_timer #(
  parameter int BIT_CYC = 60,
  parameter int T0H_CYC = 19,
  parameter int T1H_CYC = 38,
  parameter int CW      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic go_i,
  input  logic bit_i,
  output logic line_o,
  output logic high_end_o,
  output logic bit_done_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          line_q, line_d;
  logic [CW-1:0] high_len;
  logic [CW-1:0] cnt_inc;

  assign high_len = bit_i ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign cnt_inc  = cnt_q + CW'(1);

  assign line_o     = line_q;
  assign bit_done_o = active_q && (cnt_q == CW'(BIT_CYC - 1));
  assign high_end_o = active_q && line_q && (cnt_q == high_len - CW'(1));

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    line_d   = line_q;
    if (go_i) begin
      // go may coincide with bit_done: a new bit restarts back to back.
      cnt_d    = '0;
      active_d = 1'b1;
      line_d   = 1'b1;
    end else if (active_q) begin
      if (cnt_q == CW'(BIT_CYC - 1)) begin
        cnt_d    = '0;
        active_d = 1'b0;
        line_d   = 1'b0;
      end else begin
        cnt_d  = cnt_inc;
        line_d = (cnt_inc < high_len);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      line_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      line_q   <= line_d;
    end
  end

endmodule

// File: rtl/ws2812_chain_driver.sv
// ---------------------------------------------------------------------------
// ws2812_chain_driver
// Serialises NUM_LEDS 24-bit colour words (LED0 first, MSB first) onto one
// WS2812-style data line, followed by a low latch gap.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   color_string  : frame, LED0 in the top 24 bits
//   brightness    : global scale, 255 = unscaled
//   start         : request one frame (only honoured in IDLE)
//   auto_refresh  : start frames back to back without start
//   to_light      : registered serial data
//   busy          : accepted start .. end of latch gap
//   done          : one-cycle pulse at end of latch gap
// ---------------------------------------------------------------------------
module ws2812_chain_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = DEF_NUM_LEDS,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int RESET_CYC = DEF_RESET_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [24*NUM_LEDS-1:0] color_string,
  input  logic [7:0]            brightness,
  input  logic                  start,
  input  logic                  auto_refresh,
  output logic                  to_light,
  output logic                  busy,
  output logic                  done
);

  localparam int FW      = 24 * NUM_LEDS;
  localparam int MAX_CYC = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(FW);

  state_e        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] latch_q, latch_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          go;
  logic          high_end;
  logic          bit_done;
  logic [FW-1:0] scaled;

  // Scale every byte of the incoming frame; only captured at frame latch.
  genvar gi;
  generate
    for (gi = 0; gi < 3 * NUM_LEDS; gi++) begin : g_scale
      assign scaled[8*gi +: 8] = scale_byte(color_string[8*gi +: 8], brightness);
    end
  endgenerate

  // The bit in flight always sits at the top of the shift register.
  ws2812_bit_timer #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .CW      (CW)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .go_i       (go),
    .bit_i      (frame_q[FW-1]),
    .line_o     (to_light),
    .high_end_o (high_end),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    go      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start || auto_refresh) begin
          state_d = HIGH;
          frame_d = scaled;
          idx_d   = '0;
          busy_d  = 1'b1;
          go      = 1'b1;
        end
      end
      HIGH: begin
        if (high_end) state_d = LOW;
      end
      LOW: begin
        if (bit_done) begin
          if (idx_q == IW'(FW - 1)) begin
            state_d = LATCH;
            latch_d = '0;
          end else begin
            state_d = HIGH;
            idx_d   = idx_q + IW'(1);
            frame_d = {frame_q[FW-2:0], 1'b0};
            go      = 1'b1;
          end
        end
      end
      LATCH: begin
        if (latch_q == CW'(RESET_CYC - 1)) begin
          state_d = IDLE;
          latch_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          latch_d = latch_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      latch_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
module tb_ws2812_chain_driver;

  localparam int NL = 2;
  localparam int BC = 6;
  localparam int T0 = 2;
  localparam int T1 = 4;
  localparam int RC = 10;
  localparam int FL = 24 * NL * BC + RC;  // accepting edge to done edge

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [47:0] color_string = '0;
  logic [7:0]  brightness = 8'd0;
  logic        start = 1'b0;
  logic        auto_refresh = 1'b0;
  logic        to_light;
  logic        busy;
  logic        done;

  int   cyc = 0;
  logic rst_edge = 1'b0;
  int   total = 0;
  int   bad = 0;

  bit   exp_bits[$];
  int   exp_done[$];

  ws2812_chain_driver #(
    .NUM_LEDS  (NL),
    .BIT_CYC   (BC),
    .T0H_CYC   (T0),
    .T1H_CYC   (T1),
    .RESET_CYC (RC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .color_string (color_string),
    .brightness   (brightness),
    .start        (start),
    .auto_refresh (auto_refresh),
    .to_light     (to_light),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_scale(input logic [7:0] c, input logic [7:0] b);
    int p;
    p = int'(c) * (int'(b) + 1);
    return 8'(p / 256);
  endfunction

  task automatic push_frame(input logic [47:0] col, input logic [7:0] br, input int accept_cyc);
    logic [7:0] sb;
    for (int led = 0; led < NL; led++) begin
      for (int by = 0; by < 3; by++) begin
        sb = model_scale(col[47 - 24*led - 8*by -: 8], br);
        for (int b = 7; b >= 0; b--) exp_bits.push_back(sb[b]);
      end
    end
    exp_done.push_back(accept_cyc + FL);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [47:0] col, input logic [7:0] br);
    color_string = col;
    brightness   = br;
    start        = 1'b1;
    push_frame(col, br, cyc + 1);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_done.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check("timeout", exp_done.size(), 0);
    repeat (3) tick();
  endtask

  // Monitor: decodes the serial line and the handshake mid-cycle.
  logic prev_tl = 1'b0;
  logic prev_done = 1'b0;
  int   high_cnt = 0;
  int   last_rise = 0;
  bit   have_rise = 1'b0;
  int   busy_run = 0;
  int   frame_no = 0;
  bit   e;
  int   d;

  always @(negedge clk) begin
    if (!rst_edge) begin
      check("rst_to_light", to_light, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      exp_bits.delete();
      exp_done.delete();
      prev_tl   = 1'b0;
      prev_done = 1'b0;
      high_cnt  = 0;
      have_rise = 1'b0;
      busy_run  = 0;
    end else begin
      if (to_light) begin
        if (!prev_tl) begin
          if (have_rise && (cyc - last_rise) < 12) check("bit_period", cyc - last_rise, BC);
          last_rise = cyc;
          have_rise = 1'b1;
          high_cnt  = 1;
        end else begin
          high_cnt++;
        end
      end else if (prev_tl) begin
        if (exp_bits.size() == 0) begin
          check("spurious_bit", exp_bits.size(), 1);
        end else begin
          e = exp_bits.pop_front();
          check("bit_high", high_cnt, e ? T1 : T0);
        end
        high_cnt = 0;
      end
      if (busy) busy_run++;
      if (done) begin
        check("done_width", prev_done, 0);
        if (exp_done.size() == 0) begin
          check("spurious_done", exp_done.size(), 1);
        end else begin
          d = exp_done.pop_front();
          check("done_cyc", cyc, d);
          check("busy_len", busy_run, FL);
          check("busy_at_done", busy, 0);
          check("bits_left", exp_bits.size(), 48 * exp_done.size());
          frame_no++;
          $display("frame %0d done at cyc %0d busy_len %0d", frame_no, cyc, busy_run);
        end
        busy_run = 0;
      end
      prev_tl   = to_light;
      prev_done = done;
    end
  end

  int a;

  initial begin
    // 1: reset held with start asserted, then quiet release
    rst   = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    rst   = 1'b1;
    start = 1'b0;
    repeat (5) begin
      tick();
      @(negedge clk);
      check("idle_to_light", to_light, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end
    tick();

    // 2: full brightness
    send_frame({24'h00CEFF, 24'h7F32A8}, 8'd255);
    wait_idle();

    // 3: scaled brightness
    send_frame({24'h00CEFF, 24'h7F32A8}, 8'd127);
    wait_idle();

    // 4: starts while busy are ignored; start right after done is taken
    send_frame({24'h123456, 24'hA5C30F}, 8'd255);
    a = cyc;
    while (cyc < a + 49) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < a + 289) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < a + 298) tick();
    send_frame({24'hF0F0F0, 24'h0180FE}, 8'd200);
    wait_idle();

    // 5: reset during bit 10, then retransmit from bit 0
    send_frame({24'h00CEFF, 24'h7F32A8}, 8'd255);
    a = cyc;
    while (cyc < a + 61) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    send_frame({24'h00CEFF, 24'h7F32A8}, 8'd255);
    wait_idle();

    // 6: auto refresh picks up new data for frame 2
    auto_refresh = 1'b1;
    send_frame({24'h112233, 24'h445566}, 8'd255);
    a = cyc;
    while (cyc < a + 100) tick();
    color_string = {24'hFEDCBA, 24'h987654};
    push_frame({24'hFEDCBA, 24'h987654}, 8'd255, a + FL + 1);
    while (cyc < a + 300) tick();
    auto_refresh = 1'b0;
    wait_idle();
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
